// File: rtl/exec_stage.sv
// exec_stage: execute stage between the register file read ports and its
// write port. Latches operands at issue, runs a single-cycle ALU operation
// or an iterative 16-step shift-add multiply, then presents the result with
// a one-cycle Load strobe and its write-back address.
//
// Optional feature macro: EXEC_MUL_EN
//   defined   : op 111 runs the multiply sequence (MULT state + accumulator)
//   undefined : op 111 goes straight to WB and issues no register write
//
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high reset
//   start  issue request, sampled only in IDLE
//   op     operation select (000 ADD .. 110 SHR, 111 MUL)
//   dest   destination register address
//   A, B   operands
//   C      result             Caddr  write-back address
//   Load   one-cycle write strobe
//   busy   high while not IDLE
//   zero   result == 0        carry  carry/borrow/overflow flag
//
// state | meaning
// IDLE  | waiting for start; operands latched on issue
// EXEC  | single-cycle ALU op; result and Load registered at exit
// MULT  | one shift-add iteration per cycle, 16 cycles
// WB    | Load visible this cycle; returns to IDLE
module exec_stage (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [3:0]  dest,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] C,
  output logic [3:0]  Caddr,
  output logic        Load,
  output logic        busy,
  output logic        zero,
  output logic        carry
);

  typedef enum logic [1:0] {IDLE, EXEC, MULT, WB} state_t;

  state_t      state, state_next;
  logic [15:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [3:0]  dest_q;
  logic [15:0] c_next;
  logic        carry_next;
  logic        load_next;
  logic        issue;

  logic [16:0] add_w, sub_w, shl_w, shr_w;

  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  // bit 16 of the 17-bit difference is the unsigned borrow
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  // the extra bit catches the last bit shifted out (0 for a zero shift)
  assign shl_w = {1'b0, a_q} << b_q[3:0];
  assign shr_w = {a_q, 1'b0} >> b_q[3:0];

`ifdef EXEC_MUL_EN
  logic [3:0]  cnt;
  logic [31:0] acc, acc_sum;

  assign acc_sum = acc + (b_q[cnt] ? ({16'h0000, a_q} << cnt) : 32'h0);
`endif

  always_comb begin
    state_next = state;
    c_next     = C;
    carry_next = carry;
    load_next  = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          issue = 1'b1;
`ifdef EXEC_MUL_EN
          state_next = (op == 3'b111) ? MULT : EXEC;
`else
          state_next = (op == 3'b111) ? WB : EXEC;
`endif
        end
      end
      EXEC: begin
        load_next  = 1'b1;
        state_next = WB;
        case (op_q)
          3'b000: begin c_next = add_w[15:0]; carry_next = add_w[16]; end
          3'b001: begin c_next = sub_w[15:0]; carry_next = sub_w[16]; end
          3'b010: begin c_next = a_q & b_q;   carry_next = 1'b0; end
          3'b011: begin c_next = a_q | b_q;   carry_next = 1'b0; end
          3'b100: begin c_next = a_q ^ b_q;   carry_next = 1'b0; end
          3'b101: begin c_next = shl_w[15:0]; carry_next = shl_w[16]; end
          3'b110: begin c_next = shr_w[16:1]; carry_next = shr_w[0]; end
          default: begin c_next = C; carry_next = carry; end
        endcase
      end
`ifdef EXEC_MUL_EN
      MULT: begin
        if (cnt == 4'hF) begin
          c_next     = acc_sum[15:0];
          carry_next = |acc_sum[31:16];
          load_next  = 1'b1;
          state_next = WB;
        end
      end
`endif
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      op_q   <= 3'b000;
      dest_q <= 4'h0;
      C      <= 16'h0000;
      Caddr  <= 4'h0;
      Load   <= 1'b0;
      busy   <= 1'b0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      Load  <= load_next;
      if (load_next) begin
        C     <= c_next;
        carry <= carry_next;
        zero  <= (c_next == 16'h0000);
        Caddr <= dest_q;
      end
      if (issue) begin
        a_q    <= A;
        b_q    <= B;
        op_q   <= op;
        dest_q <= dest;
      end
    end
  end

`ifdef EXEC_MUL_EN
  always_ff @(posedge clk) begin
    if (clear || issue) begin
      cnt <= 4'h0;
      acc <= 32'h0;
    end else if (state == MULT) begin
      cnt <= cnt + 4'h1;
      acc <= acc_sum;
    end
  end
`endif

endmodule
